// File: rtl/vrc_irq_pkg.sv
// vrc_irq_pkg: register select encodings, control bit layout and prescaler defaults for the VRC4 IRQ counter
package vrc_irq_pkg;

  localparam logic [1:0] REG_LATCH_LO = 2'd0;
  localparam logic [1:0] REG_LATCH_HI = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_ACK      = 2'd3;

  localparam int CTL_A = 0;
  localparam int CTL_E = 1;
  localparam int CTL_M = 2;

  localparam int DEF_PRESCALE_RELOAD = 341;
  localparam int DEF_PRESCALE_STEP   = 3;

  // Field order makes ctl_t'(reg_data[2:0]) line up with the CTL_* indices.
  typedef struct packed {
    logic m;
    logic e;
    logic a;
  } ctl_t;

endpackage

// File: rtl/vrc_irq_prescaler.sv
// vrc_irq_prescaler: scanline prescaler, PPU dots per scanline counted down STEP dots per CPU cycle
module vrc_irq_prescaler
  import vrc_irq_pkg::*;
#(
  parameter int RELOAD = DEF_PRESCALE_RELOAD,
  parameter int STEP   = DEF_PRESCALE_STEP
) (
  input  logic m2,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic tick
);

  logic [8:0] presc_q, presc_d;

  assign tick = run && (presc_q <= 9'(STEP));

  // Reload on enable, hold when not running, otherwise count down carrying the remainder across scanlines.
  always_comb begin
    presc_d = load ? 9'(RELOAD) :
              !run ? presc_q :
              tick ? presc_q + 9'(RELOAD - STEP) :
                     presc_q - 9'(STEP);
  end

  // Prescaler register.
  always_ff @(posedge m2) begin
    if (rst) presc_q <= 9'(RELOAD);
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/vrc4_irq_counter.sv
// vrc4_irq_counter: VRC4 IRQ counter with reload latch, scanline/cycle modes and open-drain irq
module vrc4_irq_counter
  import vrc_irq_pkg::*;
#(
  parameter int PRESCALE_RELOAD = DEF_PRESCALE_RELOAD,
  parameter int PRESCALE_STEP   = DEF_PRESCALE_STEP
) (
  input  logic       m2,
  input  logic       rst,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  output logic       irq,
  output logic       irq_pending,
  output logic [7:0] counter
);

  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  ctl_t       ctl_q, ctl_d;
  logic       pending_q, pending_d;
  logic       wr_lo, wr_hi, wr_ctrl, wr_ack;
  logic       presc_tick, tick, ovf;
  logic       unused_data;

  assign wr_lo   = reg_we && reg_sel == REG_LATCH_LO;
  assign wr_hi   = reg_we && reg_sel == REG_LATCH_HI;
  assign wr_ctrl = reg_we && reg_sel == REG_CTRL;
  assign wr_ack  = reg_we && reg_sel == REG_ACK;

  // A control write stalls the prescaler for its cycle so the discarded tick leaves no trace.
  vrc_irq_prescaler #(
    .RELOAD(PRESCALE_RELOAD),
    .STEP  (PRESCALE_STEP)
  ) u_presc (
    .m2  (m2),
    .rst (rst),
    .load(wr_ctrl && reg_data[CTL_E]),
    .run (ctl_q.e && !ctl_q.m && !wr_ctrl),
    .tick(presc_tick)
  );

  assign tick = ctl_q.e && (ctl_q.m || presc_tick) && !wr_ctrl;
  assign ovf  = tick && counter_q == 8'hFF;

  // Next state: control write beats everything, overflow beats acknowledge, reload always uses the old latch.
  always_comb begin
    latch_d   = {wr_hi ? reg_data[3:0] : latch_q[7:4], wr_lo ? reg_data[3:0] : latch_q[3:0]};
    ctl_d     = wr_ctrl ? ctl_t'(reg_data[2:0]) : wr_ack ? ctl_t'({ctl_q.m, ctl_q.a, ctl_q.a}) : ctl_q;
    counter_d = ((wr_ctrl && reg_data[CTL_E]) || ovf) ? latch_q : tick ? counter_q + 8'd1 : counter_q;
    pending_d = !wr_ctrl && (ovf || (pending_q && !wr_ack));
  end

  // State registers; reset wins over any write in the same cycle.
  always_ff @(posedge m2) begin
    if (rst) begin
      latch_q   <= 8'h00;
      counter_q <= 8'h00;
      ctl_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      ctl_q     <= ctl_d;
      pending_q <= pending_d;
    end
  end

  assign irq         = pending_q ? 1'b0 : 1'bz;
  assign irq_pending = pending_q;
  assign counter     = counter_q;
  assign unused_data = ^reg_data[7:4];

endmodule

// File: tb/tb_vrc4_irq_counter.sv
// tb_vrc4_irq_counter: directed plan items plus random register traffic against a dot-accumulating reference model
module tb_vrc4_irq_counter;

  localparam int DOTS = 341;
  localparam int STEP = 3;

  logic       m2 = 1'b0;
  logic       rst = 1'b1;
  logic       reg_we = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_data = 8'd0;
  wire        irq;
  logic       irq_pending;
  logic [7:0] counter;

  pullup (irq);

  vrc4_irq_counter dut (
    .m2         (m2),
    .rst        (rst),
    .reg_we     (reg_we),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .irq        (irq),
    .irq_pending(irq_pending),
    .counter    (counter)
  );

  always #5 m2 = ~m2;

  int vectors = 0;
  int miscompares = 0;

  int m_latch, m_cnt, m_dots;
  bit m_a, m_e, m_m, m_pend;

  task automatic chk(string tag, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: scanline mode accumulates PPU dots and ticks each time a full scanline's worth is reached.
  task automatic model_step(bit r, bit we, logic [1:0] sel, logic [7:0] d);
    bit wc, wa, st, tk, ovf;
    int old;
    if (r) begin
      m_latch = 0; m_cnt = 0; m_dots = 0;
      m_a = 0; m_e = 0; m_m = 0; m_pend = 0;
      return;
    end
    wc = we && sel == 2'd2;
    wa = we && sel == 2'd3;
    st = 0;
    if (m_e && !m_m && !wc) begin
      m_dots += STEP;
      if (m_dots >= DOTS) begin
        m_dots -= DOTS;
        st = 1;
      end
    end
    tk  = m_e && (m_m || st) && !wc;
    old = m_latch;
    if (wc) begin
      m_a = d[0]; m_e = d[1]; m_m = d[2]; m_pend = 0;
      if (d[1]) begin
        m_cnt = old;
        m_dots = 0;
      end
    end else begin
      ovf = 0;
      if (tk) begin
        if (m_cnt == 255) begin
          m_cnt = old;
          ovf = 1;
        end else m_cnt++;
      end
      if (wa) begin
        m_pend = 0;
        m_e = m_a;
      end
      if (ovf) m_pend = 1;
    end
    if (we && sel == 2'd0) m_latch = (m_latch & 'hF0) | (int'(d) & 'h0F);
    if (we && sel == 2'd1) m_latch = (m_latch & 'h0F) | ((int'(d) & 'h0F) << 4);
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later, return to the falling edge.
  task automatic cyc(bit r, bit we, logic [1:0] sel, logic [7:0] d);
    rst = r; reg_we = we; reg_sel = sel; reg_data = d;
    @(posedge m2);
    model_step(r, we, sel, d);
    #1;
    chk("counter", int'(counter), m_cnt);
    chk("pending", int'(irq_pending), int'(m_pend));
    chk("irq", int'(irq), m_pend ? 0 : 1);
    @(negedge m2);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 8'd0);
  endtask

  initial begin
    @(negedge m2);
    cyc(1, 0, 2'd0, 8'd0);
    cyc(1, 0, 2'd0, 8'd0);
    idle(1000);
    chk("idle_counter", int'(counter), 0);
    chk("idle_irq", int'(irq), 1);

    cyc(0, 1, 2'd0, 8'h0E);
    cyc(0, 1, 2'd1, 8'h0F);
    cyc(0, 1, 2'd2, 8'h06);
    chk("cyc_load", int'(counter), 8'hFE);
    idle(1);
    chk("cyc_ff", int'(counter), 8'hFF);
    chk("cyc_ff_irq", int'(irq), 1);
    idle(1);
    chk("cyc_reload", int'(counter), 8'hFE);
    chk("cyc_irq", int'(irq), 0);

    cyc(1, 0, 2'd0, 8'd0);
    cyc(0, 1, 2'd0, 8'h0F);
    cyc(0, 1, 2'd1, 8'h0F);
    cyc(0, 1, 2'd2, 8'h02);
    for (int i = 1; i <= 114; i++) begin
      idle(1);
      if (i == 113) chk("scan_113", int'(irq_pending), 0);
    end
    chk("scan_114", int'(irq), 0);
    cyc(0, 1, 2'd3, 8'h00);
    chk("ack_irq", int'(irq), 1);
    idle(200);
    chk("frozen", int'(counter), 8'hFF);

    cyc(0, 1, 2'd1, 8'h0F);
    cyc(0, 1, 2'd0, 8'h00);
    cyc(0, 1, 2'd2, 8'h07);
    for (int i = 1; i <= 16; i++) begin
      idle(1);
      chk("ovf16", int'(irq_pending), i == 16 ? 1 : 0);
    end
    cyc(0, 1, 2'd3, 8'h00);
    chk("ack_cont", int'(counter), 8'hF1);
    for (int i = 1; i <= 15; i++) begin
      idle(1);
      chk("reovf", int'(irq_pending), i == 15 ? 1 : 0);
    end
    cyc(0, 1, 2'd3, 8'h00);
    idle(14);
    chk("pre_ack_ovf", int'(counter), 8'hFF);
    cyc(0, 1, 2'd3, 8'h00);
    chk("ack_ovf_irq", int'(irq), 0);
    idle(15);
    cyc(0, 1, 2'd2, 8'h07);
    chk("ctl_ovf_cnt", int'(counter), 8'hF0);
    chk("ctl_ovf_irq", int'(irq), 1);

    idle(16);
    chk("pre_rst", int'(irq), 0);
    cyc(1, 1, 2'd2, 8'h07);
    chk("rst_cnt", int'(counter), 0);
    chk("rst_irq", int'(irq), 1);
    idle(5);
    chk("rst_frozen", int'(counter), 0);

    for (int i = 0; i < 4000; i++) begin
      logic [1:0] s;
      logic [7:0] d;
      bit w;
      s = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      w = ($urandom_range(0, 5) == 0);
      if (s == 2'd1 && $urandom_range(0, 3) != 0) d = 8'h0F;
      if (s == 2'd2 && $urandom_range(0, 2) != 0) d[1] = 1'b1;
      cyc($urandom_range(0, 599) == 0, w, s, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
